pipelined_ctrl: RTL and testbench
=================================

# pipelined_ctrl

Pipelined control unit for the ARM pipelined processor, sitting directly upstream of the datapath. It decodes the instruction held in the Decode stage and carries the resulting control bits through Execute, Memory and Writeback registers. In Execute it evaluates the condition field against an internal NZCV flag register and gates all architectural side effects (register write, memory write, PC write, flag update) on the result. It produces every control input the datapath consumes, each aligned to the stage that uses it.

## Interface
- No parameters.
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- InstrD  in  32  Decode-stage instruction; fields used: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  Execute-stage ALU flags {N,Z,C,V}
- Enable  in  1  global pipeline advance; 0 holds every register including flags
- FlushE  in  1  replace Decode→Execute transfer with a bubble
- RegSrcD  out  2  register-address select, Decode
- ImmSrcD  out  2  immediate format select, Decode
- ALUSrcE  out  1  SrcB select, Execute
- ALUControlE  out  3  ALU operation, Execute
- BranchTakenE  out  1  conditional branch resolved taken, Execute
- MemWriteM  out  1  data-memory write strobe, Memory
- MemtoRegW  out  1  result select, Writeback
- RegWriteW  out  1  register-file write, Writeback
- PCSrcW  out  1  Result written to PC, Writeback
- BrLW  out  1  link write of PC+4 into R14, Writeback
- PCWrPendingF  out  1  PCSrcD | PCSrcE | PCSrcM, for fetch stalling

## Operation
- Decode (combinational on InstrD)
  - Op=00, data processing: RegSrc=00, ImmSrc=00, ALUSrc=Funct[5], RegWrite=1.
    - cmd=Funct[4:1] maps as: AND 0000→010, SUB 0010→001, ADD 0100→000, ORR 1100→011, EOR 0001→100, MOV 1101→101.
    - CMP 1010 uses ALUControl 001, RegWrite=0, flags written regardless of S.
    - Any other cmd: ALUControl 000, RegWrite=0, FlagW=00.
  - Op=01, memory: ALUSrc=1, ImmSrc=01, ALUControl 000.
    - LDR (Funct[0]=1): RegSrc=00, RegWrite=1, MemtoReg=1.
    - STR: RegSrc=10, MemWrite=1.
  - Op=10, branch: RegSrc=01, ImmSrc=10, ALUSrc=1, ALUControl 000, Branch=1, BrL=Funct[4].
  - Op=11: all enables 0.
  - FlagW[1] (N,Z) = S for data processing. FlagW[0] (C,V) = S and the cmd is ADD or SUB. CMP forces FlagW=11.
  - PCSrcD = RegWrite & (Rd==15).
- Pipeline registers: D→E, E→M and M→W, each carrying the control bits plus Cond and FlagW into E.
  - Priority on each edge: reset (all 0) > FlushE (E register only, all 0) > Enable=0 (hold) > load.
- Condition check (Execute): CondExE from CondE and the flag register.
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL is 1. Code 1111 is 0.
- Gating into the M register: RegWrite, MemWrite, PCSrc and BrL are each ANDed with CondExE.
- BranchTakenE = BranchE & CondExE.
- Flag register: 4 bits, reset 0000.
  - N,Z ← ALUFlags[3:2] when FlagWE[1] & CondExE & Enable.
  - C,V ← ALUFlags[1:0] when FlagWE[0] & CondExE & Enable.
  - Loaded regardless of FlushE; FlushE affects only the next E content.

## Timing
- Decode outputs are combinational and valid in the same cycle as InstrD.
- Latency from InstrD to each output: E outputs +1 cycle, MemWriteM +2, W outputs +3.
- Flags written by an instruction in E at cycle n are visible to the condition check of the instruction in E at n+1. Back-to-back CMP followed by a conditional instruction needs no stall.
- Reset: every output is 0, every pipeline register is 0, flags are 0000. A reset asserted mid-stream discards all in-flight instructions in one edge.
- FlushE together with Enable=0: E becomes a bubble, while the M and W registers hold.
- A bubble (all 0) never writes registers, memory, PC or flags.

## Test plan
- Reset mid-stream: assert reset with an ADD in each stage → next edge all outputs 0, flags 0000.
- ADD R1,R2,R3 (0xE0821003) → ALUControlE=000 at +1; RegWriteW=1, MemtoRegW=0 at +3.
- CMP R1,R1 with ALUFlags=0100, then BEQ (0x0A000002) → BranchTakenE=1 at +1 after the CMP. Repeat with BNE → BranchTakenE=0.
- STREQ with Z=0 → MemWriteM stays 0. With Z=1 → MemWriteM=1 at +2.
- BL (0xEB000004) → BrLW=1 at +3. PCWrPendingF=0, since a branch resolves via BranchTakenE.
- LDR PC,[R0] → PCWrPendingF=1 for 3 cycles, then PCSrcW=1 and MemtoRegW=1 at +3. Enable=0 for 2 cycles mid-flight → all outputs frozen, each arrival delayed by 2. FlushE during Decode → no writes.

Source files
------------

// File: rtl/pipelined_ctrl.sv
// pipelined_ctrl: ARM pipelined control unit.
// Decodes in D, carries control through E/M/W, checks conditions in E.
module pipelined_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [3:0]  ALUFlags,
  input  logic        Enable,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic        BranchTakenE,
  output logic        MemWriteM,
  output logic        MemtoRegW,
  output logic        RegWriteW,
  output logic        PCSrcW,
  output logic        BrLW,
  output logic        PCWrPendingF
);

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] flagw;
    logic [2:0] aluc;
    logic       alusrc;
    logic       branch;
    logic       brl;
    logic       pcsrc;
    logic       memtoreg;
    logic       memwrite;
    logic       regwrite;
  } de_t;

  typedef struct packed {
    logic brl;
    logic pcsrc;
    logic memtoreg;
    logic memwrite;
    logic regwrite;
  } em_t;

  typedef struct packed {
    logic brl;
    logic pcsrc;
    logic memtoreg;
    logic regwrite;
  } mw_t;

  logic [1:0] op_d;
  logic [5:0] funct_d;
  logic [3:0] cmd_d;
  logic       s_d;
  logic       rd15_d;
  logic       unused_instr;

  de_t        e_d, e_q;
  em_t        m_d, m_q;
  mw_t        w_d, w_q;
  logic [3:0] flags_d, flags_q;
  logic       cond_ex;

  assign op_d    = InstrD[27:26];
  assign funct_d = InstrD[25:20];
  assign cmd_d   = funct_d[4:1];
  assign s_d     = funct_d[0];
  assign rd15_d  = (InstrD[15:12] == 4'hF);
  assign unused_instr = ^{InstrD[19:16], InstrD[11:0]};

  // Main decoder: control bundle for the instruction in Decode
  always_comb begin
    e_d      = '0;
    RegSrcD  = 2'b00;
    ImmSrcD  = 2'b00;
    e_d.cond = InstrD[31:28];
    unique case (op_d)
      2'b00: begin
        e_d.alusrc   = funct_d[5];
        e_d.regwrite = 1'b1;
        e_d.flagw[1] = s_d;
        unique case (cmd_d)
          4'b0000: e_d.aluc = 3'b010;
          4'b0010: begin
            e_d.aluc     = 3'b001;
            e_d.flagw[0] = s_d;
          end
          4'b0100: begin
            e_d.aluc     = 3'b000;
            e_d.flagw[0] = s_d;
          end
          4'b1100: e_d.aluc = 3'b011;
          4'b0001: e_d.aluc = 3'b100;
          4'b1101: e_d.aluc = 3'b101;
          4'b1010: begin
            e_d.aluc     = 3'b001;
            e_d.regwrite = 1'b0;
            e_d.flagw    = 2'b11;
          end
          default: begin
            e_d.aluc     = 3'b000;
            e_d.regwrite = 1'b0;
            e_d.flagw    = 2'b00;
          end
        endcase
      end
      2'b01: begin
        e_d.alusrc = 1'b1;
        ImmSrcD    = 2'b01;
        if (funct_d[0]) begin
          e_d.regwrite = 1'b1;
          e_d.memtoreg = 1'b1;
        end else begin
          RegSrcD      = 2'b10;
          e_d.memwrite = 1'b1;
        end
      end
      2'b10: begin
        RegSrcD    = 2'b01;
        ImmSrcD    = 2'b10;
        e_d.alusrc = 1'b1;
        e_d.branch = 1'b1;
        e_d.brl    = funct_d[4];
      end
      default: ;
    endcase
    e_d.pcsrc = e_d.regwrite & rd15_d;
  end

  // Condition check of the Execute instruction against stored NZCV
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    unique case (e_q.cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = ~z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = ~c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = ~n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = ~v;
      4'h8: cond_ex = c & ~z;
      4'h9: cond_ex = ~c | z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = ~z & (n == v);
      4'hD: cond_ex = z | (n != v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Side effects leaving Execute are gated by the condition result
  always_comb begin
    m_d.regwrite = e_q.regwrite & cond_ex;
    m_d.memwrite = e_q.memwrite & cond_ex;
    m_d.pcsrc    = e_q.pcsrc & cond_ex;
    m_d.brl      = e_q.brl & cond_ex;
    m_d.memtoreg = e_q.memtoreg;
    w_d.regwrite = m_q.regwrite;
    w_d.memtoreg = m_q.memtoreg;
    w_d.pcsrc    = m_q.pcsrc;
    w_d.brl      = m_q.brl;
  end

  // Flag update: N,Z and C,V enabled separately
  always_comb begin
    flags_d = flags_q;
    if (Enable & cond_ex & e_q.flagw[1])
      flags_d[3:2] = ALUFlags[3:2];
    if (Enable & cond_ex & e_q.flagw[0])
      flags_d[1:0] = ALUFlags[1:0];
  end

  // D->E register: flush makes a bubble even while stalled
  always_ff @(posedge clk) begin
    if (reset)       e_q <= '0;
    else if (FlushE) e_q <= '0;
    else if (Enable) e_q <= e_d;
  end

  // E->M and M->W registers plus NZCV
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q     <= '0;
      w_q     <= '0;
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
      if (Enable) begin
        m_q <= m_d;
        w_q <= w_d;
      end
    end
  end

  assign ALUSrcE      = e_q.alusrc;
  assign ALUControlE  = e_q.aluc;
  assign BranchTakenE = e_q.branch & cond_ex;
  assign MemWriteM    = m_q.memwrite;
  assign MemtoRegW    = w_q.memtoreg;
  assign RegWriteW    = w_q.regwrite;
  assign PCSrcW       = w_q.pcsrc;
  assign BrLW         = w_q.brl;
  assign PCWrPendingF = e_d.pcsrc | e_q.pcsrc | m_q.pcsrc;

endmodule

// File: tb/tb_pipelined_ctrl.sv
// tb_pipelined_ctrl: scoreboard bench for pipelined_ctrl.
// Expectations are queued with a due cycle and checked when reached.
module tb_pipelined_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] InstrD;
  logic [3:0]  ALUFlags;
  logic        Enable;
  logic        FlushE;
  logic [1:0]  RegSrcD;
  logic [1:0]  ImmSrcD;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic        BranchTakenE;
  logic        MemWriteM;
  logic        MemtoRegW;
  logic        RegWriteW;
  logic        PCSrcW;
  logic        BrLW;
  logic        PCWrPendingF;

  pipelined_ctrl dut (
    .clk(clk), .reset(reset), .InstrD(InstrD),
    .ALUFlags(ALUFlags), .Enable(Enable), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM),
    .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW),
    .PCSrcW(PCSrcW), .BrLW(BrLW), .PCWrPendingF(PCWrPendingF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP   = 32'h0C00_0000;
  localparam logic [31:0] ADD   = 32'hE082_1003;
  localparam logic [31:0] ORRI  = 32'hE382_1005;
  localparam logic [31:0] SUB   = 32'hE042_1003;
  localparam logic [31:0] EOR   = 32'hE022_1003;
  localparam logic [31:0] MOV   = 32'hE1A2_1003;
  localparam logic [31:0] AND   = 32'hE002_1003;
  localparam logic [31:0] TST   = 32'hE111_0003;
  localparam logic [31:0] ANDS  = 32'hE012_1003;
  localparam logic [31:0] CMP   = 32'hE151_0001;
  localparam logic [31:0] CMPNE = 32'h1151_0001;
  localparam logic [31:0] BEQ   = 32'h0A00_0002;
  localparam logic [31:0] BNE   = 32'h1A00_0002;
  localparam logic [31:0] BVS   = 32'h6A00_0002;
  localparam logic [31:0] BMI   = 32'h4A00_0002;
  localparam logic [31:0] BL    = 32'hEB00_0004;
  localparam logic [31:0] BLNV  = 32'hFB00_0004;
  localparam logic [31:0] STREQ = 32'h0580_1000;
  localparam logic [31:0] LDR1  = 32'hE590_1000;
  localparam logic [31:0] LDRPC = 32'hE590_F000;

  localparam int I_ALUC = 0;
  localparam int I_ASRC = 1;
  localparam int I_BT   = 2;
  localparam int I_MW   = 3;
  localparam int I_M2R  = 4;
  localparam int I_RW   = 5;
  localparam int I_PCS  = 6;
  localparam int I_BRL  = 7;
  localparam int I_PCP  = 8;
  localparam int I_RS   = 9;
  localparam int I_IS   = 10;

  string nm [11] = '{"ALUControlE", "ALUSrcE", "BranchTakenE",
                     "MemWriteM", "MemtoRegW", "RegWriteW",
                     "PCSrcW", "BrLW", "PCWrPendingF",
                     "RegSrcD", "ImmSrcD"};

  typedef struct {
    int         due;
    int         id;
    logic [3:0] val;
  } exp_t;

  exp_t sb [$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] ins [];
  logic [3:0]  af  [];
  logic        en  [];
  logic        fl  [];
  logic        rs  [];

  function automatic logic [3:0] obs(int id);
    case (id)
      I_ALUC:  obs = {1'b0, ALUControlE};
      I_ASRC:  obs = {3'b0, ALUSrcE};
      I_BT:    obs = {3'b0, BranchTakenE};
      I_MW:    obs = {3'b0, MemWriteM};
      I_M2R:   obs = {3'b0, MemtoRegW};
      I_RW:    obs = {3'b0, RegWriteW};
      I_PCS:   obs = {3'b0, PCSrcW};
      I_BRL:   obs = {3'b0, BrLW};
      I_PCP:   obs = {3'b0, PCWrPendingF};
      I_RS:    obs = {2'b0, RegSrcD};
      default: obs = {2'b0, ImmSrcD};
    endcase
  endfunction

  function automatic logic cond_ok(logic [3:0] cc, logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: cond_ok = z;
      4'h1: cond_ok = !z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = !c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = !n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = !v;
      4'h8: cond_ok = c && !z;
      4'h9: cond_ok = !c || z;
      4'hA: cond_ok = (n == v);
      4'hB: cond_ok = (n != v);
      4'hC: cond_ok = !z && (n == v);
      4'hD: cond_ok = z || (n != v);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  endfunction

  task automatic expect_at(int due, int id, logic [3:0] v);
    sb.push_back('{due, id, v});
  endtask

  task automatic prog_new(int n);
    ins = new[n];
    af  = new[n];
    en  = new[n];
    fl  = new[n];
    rs  = new[n];
    for (int k = 0; k < n; k++) begin
      ins[k] = NOP;
      af[k]  = 4'h0;
      en[k]  = 1'b1;
      fl[k]  = 1'b0;
      rs[k]  = 1'b0;
    end
  endtask

  task automatic test_reset();
    int b = cyc;
    prog_new(3);
    for (int k = 0; k < 3; k++) rs[k] = 1'b1;
    for (int id = 0; id < 11; id++) expect_at(b + 2, id, 4'h0);
    for (int k = 0; k < ins.size(); k++) begin
      InstrD = ins[k]; ALUFlags = af[k];
      Enable = en[k]; FlushE = fl[k]; reset = rs[k];
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          n_cmp++;
          if (obs(sb[i].id) !== sb[i].val) begin
            n_bad++;
            $display("FAIL reset %s cyc %0d: got %0h want %0h",
                     nm[sb[i].id], cyc, obs(sb[i].id), sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); cyc++; #1;
    end
  endtask

  task automatic test_dp();
    int b = cyc;
    logic [31:0] p [7] = '{ADD, ORRI, SUB, EOR, MOV, AND, TST};
    logic [2:0]  a [7] = '{3'b000, 3'b011, 3'b001, 3'b100,
                           3'b101, 3'b010, 3'b000};
    prog_new(10);
    for (int j = 0; j < 7; j++) begin
      ins[j] = p[j];
      expect_at(b + j, I_RS, 4'h0);
      expect_at(b + j, I_IS, 4'h0);
      expect_at(b + j + 1, I_ALUC, {1'b0, a[j]});
      expect_at(b + j + 1, I_ASRC, (j == 1) ? 4'h1 : 4'h0);
      expect_at(b + j + 3, I_RW, (j < 6) ? 4'h1 : 4'h0);
      expect_at(b + j + 3, I_M2R, 4'h0);
    end
    for (int k = 0; k < ins.size(); k++) begin
      InstrD = ins[k]; ALUFlags = af[k];
      Enable = en[k]; FlushE = fl[k]; reset = rs[k];
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          n_cmp++;
          if (obs(sb[i].id) !== sb[i].val) begin
            n_bad++;
            $display("FAIL dp %s cyc %0d: got %0h want %0h",
                     nm[sb[i].id], cyc, obs(sb[i].id), sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); cyc++; #1;
    end
  endtask

  task automatic test_cond();
    int b = cyc;
    logic [3:0] fp [7] = '{4'b0100, 4'b1000, 4'b0010, 4'b0001,
                           4'b1001, 4'b0110, 4'b0000};
    prog_new(7 * 17 + 1);
    for (int g = 0; g < 7; g++) begin
      ins[g * 17]    = CMP;
      af[g * 17 + 1] = fp[g];
      for (int j = 0; j < 16; j++) begin
        logic [3:0] cc = j[3:0];
        ins[g * 17 + 1 + j] = {cc, 28'hA00_0002};
        expect_at(b + g * 17 + j + 2, I_BT,
                  {3'b0, cond_ok(cc, fp[g])});
      end
    end
    for (int k = 0; k < ins.size(); k++) begin
      InstrD = ins[k]; ALUFlags = af[k];
      Enable = en[k]; FlushE = fl[k]; reset = rs[k];
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          n_cmp++;
          if (obs(sb[i].id) !== sb[i].val) begin
            n_bad++;
            $display("FAIL cond %s cyc %0d: got %0h want %0h",
                     nm[sb[i].id], cyc, obs(sb[i].id), sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); cyc++; #1;
    end
  endtask

  task automatic test_flags();
    int b = cyc;
    prog_new(9);
    ins[0] = CMP;
    ins[1] = ANDS;  af[1] = 4'b0011;
    ins[2] = BVS;   af[2] = 4'b1100;
    ins[3] = BMI;
    ins[4] = CMPNE;
    ins[5] = BEQ;   af[5] = 4'b0000;
    ins[6] = ADD;
    ins[7] = BEQ;   af[7] = 4'b0000;
    expect_at(b + 3, I_BT, 4'h1);
    expect_at(b + 4, I_BT, 4'h1);
    expect_at(b + 6, I_BT, 4'h1);
    expect_at(b + 8, I_BT, 4'h1);
    for (int k = 0; k < ins.size(); k++) begin
      InstrD = ins[k]; ALUFlags = af[k];
      Enable = en[k]; FlushE = fl[k]; reset = rs[k];
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          n_cmp++;
          if (obs(sb[i].id) !== sb[i].val) begin
            n_bad++;
            $display("FAIL flags %s cyc %0d: got %0h want %0h",
                     nm[sb[i].id], cyc, obs(sb[i].id), sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); cyc++; #1;
    end
  endtask

  task automatic test_mem();
    int b = cyc;
    prog_new(9);
    ins[0] = CMP;
    ins[1] = STREQ; af[1] = 4'b0000;
    ins[2] = CMP;
    ins[3] = STREQ; af[3] = 4'b0100;
    ins[4] = LDR1;
    expect_at(b + 1, I_RS, 4'h2);
    expect_at(b + 1, I_IS, 4'h1);
    expect_at(b + 2, I_ASRC, 4'h1);
    expect_at(b + 3, I_MW, 4'h0);
    expect_at(b + 4, I_RW, 4'h0);
    expect_at(b + 4, I_RS, 4'h0);
    expect_at(b + 4, I_IS, 4'h1);
    expect_at(b + 4, I_PCP, 4'h0);
    expect_at(b + 5, I_MW, 4'h1);
    expect_at(b + 6, I_MW, 4'h0);
    expect_at(b + 6, I_RW, 4'h0);
    expect_at(b + 7, I_M2R, 4'h1);
    expect_at(b + 7, I_RW, 4'h1);
    expect_at(b + 7, I_PCS, 4'h0);
    for (int k = 0; k < ins.size(); k++) begin
      InstrD = ins[k]; ALUFlags = af[k];
      Enable = en[k]; FlushE = fl[k]; reset = rs[k];
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          n_cmp++;
          if (obs(sb[i].id) !== sb[i].val) begin
            n_bad++;
            $display("FAIL mem %s cyc %0d: got %0h want %0h",
                     nm[sb[i].id], cyc, obs(sb[i].id), sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); cyc++; #1;
    end
  endtask

  task automatic test_bl();
    int b = cyc;
    prog_new(6);
    ins[0] = BL;
    ins[1] = BLNV;
    expect_at(b, I_RS, 4'h1);
    expect_at(b, I_IS, 4'h2);
    expect_at(b, I_PCP, 4'h0);
    expect_at(b + 1, I_BT, 4'h1);
    expect_at(b + 1, I_ASRC, 4'h1);
    expect_at(b + 1, I_PCP, 4'h0);
    expect_at(b + 2, I_BT, 4'h0);
    expect_at(b + 2, I_PCP, 4'h0);
    expect_at(b + 3, I_BRL, 4'h1);
    expect_at(b + 3, I_RW, 4'h0);
    expect_at(b + 3, I_PCS, 4'h0);
    expect_at(b + 4, I_BRL, 4'h0);
    for (int k = 0; k < ins.size(); k++) begin
      InstrD = ins[k]; ALUFlags = af[k];
      Enable = en[k]; FlushE = fl[k]; reset = rs[k];
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          n_cmp++;
          if (obs(sb[i].id) !== sb[i].val) begin
            n_bad++;
            $display("FAIL bl %s cyc %0d: got %0h want %0h",
                     nm[sb[i].id], cyc, obs(sb[i].id), sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); cyc++; #1;
    end
  endtask

  // LDR PC plain, then with a 2-cycle stall behind an ORR
  task automatic test_ldr_stall();
    int b = cyc;
    prog_new(4 + 7);
    ins[0] = LDRPC;
    for (int t = 0; t < 3; t++) expect_at(b + t, I_PCP, 4'h1);
    expect_at(b + 3, I_PCP, 4'h0);
    expect_at(b + 3, I_PCS, 4'h1);
    expect_at(b + 3, I_M2R, 4'h1);
    expect_at(b + 3, I_RW, 4'h1);
    ins[4] = LDRPC;
    ins[5] = ORRI;
    en[6]  = 1'b0;
    en[7]  = 1'b0;
    for (int t = 4; t < 9; t++) expect_at(b + t, I_PCP, 4'h1);
    for (int t = 6; t < 9; t++) expect_at(b + t, I_ALUC, 4'h3);
    expect_at(b + 7, I_PCS, 4'h0);
    expect_at(b + 8, I_PCS, 4'h0);
    expect_at(b + 9, I_ALUC, 4'h0);
    expect_at(b + 9, I_PCP, 4'h0);
    expect_at(b + 9, I_PCS, 4'h1);
    expect_at(b + 9, I_M2R, 4'h1);
    expect_at(b + 10, I_RW, 4'h1);
    expect_at(b + 10, I_PCS, 4'h0);
    for (int k = 0; k < ins.size(); k++) begin
      InstrD = ins[k]; ALUFlags = af[k];
      Enable = en[k]; FlushE = fl[k]; reset = rs[k];
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          n_cmp++;
          if (obs(sb[i].id) !== sb[i].val) begin
            n_bad++;
            $display("FAIL ldr_stall %s cyc %0d: got %0h want %0h",
                     nm[sb[i].id], cyc, obs(sb[i].id), sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); cyc++; #1;
    end
  endtask

  // Flush of LDR PC, then flush during a stall
  task automatic test_flush();
    int b = cyc;
    prog_new(4 + 7);
    ins[0] = LDRPC;
    fl[0]  = 1'b1;
    expect_at(b, I_PCP, 4'h1);
    expect_at(b + 1, I_PCP, 4'h0);
    expect_at(b + 3, I_PCS, 4'h0);
    expect_at(b + 3, I_RW, 4'h0);
    expect_at(b + 3, I_M2R, 4'h0);
    ins[5] = ADD;
    ins[6] = SUB;
    fl[7]  = 1'b1;
    en[7]  = 1'b0;
    expect_at(b + 7, I_ALUC, 4'h1);
    expect_at(b + 8, I_ALUC, 4'h0);
    expect_at(b + 8, I_RW, 4'h0);
    expect_at(b + 9, I_RW, 4'h1);
    expect_at(b + 10, I_RW, 4'h0);
    for (int k = 0; k < ins.size(); k++) begin
      InstrD = ins[k]; ALUFlags = af[k];
      Enable = en[k]; FlushE = fl[k]; reset = rs[k];
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          n_cmp++;
          if (obs(sb[i].id) !== sb[i].val) begin
            n_bad++;
            $display("FAIL flush %s cyc %0d: got %0h want %0h",
                     nm[sb[i].id], cyc, obs(sb[i].id), sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); cyc++; #1;
    end
  endtask

  task automatic test_reset_midstream();
    int b = cyc;
    prog_new(9);
    ins[0] = CMP;
    for (int k = 1; k < 6; k++) ins[k] = ADD;
    af[1]  = 4'b0100;
    rs[4]  = 1'b1;
    ins[6] = BNE;
    expect_at(b + 4, I_RW, 4'h1);
    for (int id = 0; id < 11; id++) expect_at(b + 5, id, 4'h0);
    expect_at(b + 6, I_RW, 4'h0);
    expect_at(b + 7, I_RW, 4'h0);
    expect_at(b + 7, I_BT, 4'h1);
    expect_at(b + 8, I_RW, 4'h1);
    for (int k = 0; k < ins.size(); k++) begin
      InstrD = ins[k]; ALUFlags = af[k];
      Enable = en[k]; FlushE = fl[k]; reset = rs[k];
      #2;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          n_cmp++;
          if (obs(sb[i].id) !== sb[i].val) begin
            n_bad++;
            $display("FAIL midreset %s cyc %0d: got %0h want %0h",
                     nm[sb[i].id], cyc, obs(sb[i].id), sb[i].val);
          end
          sb.delete(i);
        end
      end
      @(posedge clk); cyc++; #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    InstrD   = NOP;
    ALUFlags = 4'h0;
    Enable   = 1'b1;
    FlushE   = 1'b0;
    test_reset();
    test_dp();
    test_cond();
    test_flags();
    test_mem();
    test_bl();
    test_ldr_stall();
    test_flush();
    test_reset_midstream();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
